// File: rtl/sumador_serie_nbits.sv
// Multi-cycle adder S = A + B + Cin that consumes CHUNK bits per clock, LSB chunk first.
// It latches the operands on start, uses a start/busy/done handshake and reports carry-out and signed overflow.
module sumador_serie_nbits #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned CHUNK = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] S,
  output logic             C,
  output logic             OV
);

  localparam int unsigned N     = WIDTH / CHUNK;
  localparam int unsigned CNT_W = (N > 1) ? $clog2(N) : 1;

  if (CHUNK < 1 || CHUNK > WIDTH || (WIDTH % CHUNK) != 0) begin : g_param_err
    $error("sumador_serie_nbits: CHUNK must divide WIDTH and lie in 1..WIDTH");
  end

  typedef enum logic {
    IDLE = 1'b0,
    SUMA = 1'b1
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic [WIDTH-1:0] s_q, s_d;
  logic             carry_q, carry_d;
  logic             c_q, c_d;
  logic             ov_q, ov_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic [CHUNK:0]   chunk_sum_c;
  logic [WIDTH-1:0] res_shift_c;
  logic             msb_cin_c;
  logic             last_c;

  // One CHUNK-wide slice of the ripple, fed by the running carry
  assign chunk_sum_c = (CHUNK+1)'(a_q[CHUNK-1:0]) + (CHUNK+1)'(b_q[CHUNK-1:0])
                     + (CHUNK+1)'(carry_q);
  // New sum chunk enters from the MSB side so the LSB chunk lands at bit 0 after N steps
  assign res_shift_c = (res_q >> CHUNK)
                     | (WIDTH'(chunk_sum_c[CHUNK-1:0]) << (WIDTH - CHUNK));
  // Carry into the top bit of the current chunk; only meaningful on the last chunk
  assign msb_cin_c   = chunk_sum_c[CHUNK-1] ^ a_q[CHUNK-1] ^ b_q[CHUNK-1];
  assign last_c      = (cnt_q == CNT_W'(N - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      s_q     <= '0;
      carry_q <= 1'b0;
      c_q     <= 1'b0;
      ov_q    <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      res_q   <= res_d;
      s_q     <= s_d;
      carry_q <= carry_d;
      c_q     <= c_d;
      ov_q    <= ov_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    res_d   = res_q;
    s_d     = s_q;
    carry_d = carry_q;
    c_d     = c_q;
    ov_d    = ov_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    cnt_d   = cnt_q;

    unique case (state_q)
      IDLE: begin
        if (start) begin
          a_d     = A;
          b_d     = B;
          carry_d = Cin;
          res_d   = '0;
          cnt_d   = '0;
          busy_d  = 1'b1;
          state_d = SUMA;
        end
      end
      SUMA: begin
        a_d     = a_q >> CHUNK;
        b_d     = b_q >> CHUNK;
        res_d   = res_shift_c;
        carry_d = chunk_sum_c[CHUNK];
        cnt_d   = cnt_q + CNT_W'(1);
        if (last_c) begin
          s_d     = res_shift_c;
          c_d     = chunk_sum_c[CHUNK];
          ov_d    = msb_cin_c ^ chunk_sum_c[CHUNK];
          done_d  = 1'b1;
          busy_d  = 1'b0;
          cnt_d   = '0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign busy = busy_q;
  assign done = done_q;
  assign S    = s_q;
  assign C    = c_q;
  assign OV   = ov_q;

endmodule

// File: tb/tb_sumador_serie_nbits.sv
// Bench for sumador_serie_nbits with three instances of WIDTH=8: CHUNK=2, CHUNK=8 and CHUNK=1.
// It applies a directed vector table, hand-written handshake sequences and random vectors checked against an 8-bit sum model.
module tb_sumador_serie_nbits;

  logic       clk;
  logic       rst;
  logic       start_v [3];
  logic [7:0] a_v     [3];
  logic [7:0] b_v     [3];
  logic       cin_v   [3];
  logic       busy_v  [3];
  logic       done_v  [3];
  logic [7:0] s_v     [3];
  logic       c_v     [3];
  logic       ov_v    [3];

  int checks = 0;
  int errors = 0;

  sumador_serie_nbits #(.WIDTH(8), .CHUNK(2)) dut_c2 (
    .clk(clk), .rst(rst), .start(start_v[0]), .A(a_v[0]), .B(b_v[0]), .Cin(cin_v[0]),
    .busy(busy_v[0]), .done(done_v[0]), .S(s_v[0]), .C(c_v[0]), .OV(ov_v[0]));

  sumador_serie_nbits #(.WIDTH(8), .CHUNK(8)) dut_c8 (
    .clk(clk), .rst(rst), .start(start_v[1]), .A(a_v[1]), .B(b_v[1]), .Cin(cin_v[1]),
    .busy(busy_v[1]), .done(done_v[1]), .S(s_v[1]), .C(c_v[1]), .OV(ov_v[1]));

  sumador_serie_nbits #(.WIDTH(8), .CHUNK(1)) dut_c1 (
    .clk(clk), .rst(rst), .start(start_v[2]), .A(a_v[2]), .B(b_v[2]), .Cin(cin_v[2]),
    .busy(busy_v[2]), .done(done_v[2]), .S(s_v[2]), .C(c_v[2]), .OV(ov_v[2]));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic       cin;
    logic [7:0] s;
    logic       c;
    logic       ov;
  } vec_t;

  function automatic int n_of(input int d);
    return (d == 0) ? 4 : ((d == 1) ? 1 : 8);
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // One add on instance d: checks latency, busy length, S hold while busy, no busy/done overlap, result
  task automatic run_add(input int d, input logic [7:0] a, input logic [7:0] b, input logic cin,
                         input logic [7:0] es, input logic ec, input logic eov, input string tag);
    int lat;
    int bcnt;
    logic [7:0] s_prev;
    logic held;
    logic overlap;
    @(negedge clk);
    a_v[d] = a; b_v[d] = b; cin_v[d] = cin; start_v[d] = 1'b1;
    s_prev = s_v[d];
    held = 1'b1;
    overlap = 1'b0;
    @(posedge clk); #1;
    start_v[d] = 1'b0;
    a_v[d] = ~a; b_v[d] = ~b; cin_v[d] = ~cin;
    bcnt = busy_v[d] ? 1 : 0;
    if (s_v[d] !== s_prev) held = 1'b0;
    lat = 0;
    while (!done_v[d] && lat < 20) begin
      @(posedge clk); #1;
      lat++;
      if (busy_v[d]) bcnt++;
      if (busy_v[d] && done_v[d]) overlap = 1'b1;
      if (!done_v[d] && s_v[d] !== s_prev) held = 1'b0;
    end
    check({tag, ".latency"}, 32'(lat), 32'(n_of(d)));
    check({tag, ".busy_cycles"}, 32'(bcnt), 32'(n_of(d)));
    check({tag, ".S_held"}, 32'(held), 32'd1);
    check({tag, ".overlap"}, 32'(overlap), 32'd0);
    check({tag, ".S"}, 32'(s_v[d]), 32'(es));
    check({tag, ".C"}, 32'(c_v[d]), 32'(ec));
    check({tag, ".OV"}, 32'(ov_v[d]), 32'(eov));
  endtask

  initial begin
    vec_t vecs [8];
    int lat;
    int ndone;
    logic [7:0] ra, rb, es;
    logic rc, ec, eov;

    vecs[0] = '{a: 8'hFF, b: 8'h01, cin: 1'b0, s: 8'h00, c: 1'b1, ov: 1'b0};
    vecs[1] = '{a: 8'h7F, b: 8'h01, cin: 1'b0, s: 8'h80, c: 1'b0, ov: 1'b1};
    vecs[2] = '{a: 8'h80, b: 8'h80, cin: 1'b0, s: 8'h00, c: 1'b1, ov: 1'b1};
    vecs[3] = '{a: 8'h00, b: 8'h00, cin: 1'b1, s: 8'h01, c: 1'b0, ov: 1'b0};
    vecs[4] = '{a: 8'h12, b: 8'h34, cin: 1'b0, s: 8'h46, c: 1'b0, ov: 1'b0};
    vecs[5] = '{a: 8'hAA, b: 8'h55, cin: 1'b1, s: 8'h00, c: 1'b1, ov: 1'b0};
    vecs[6] = '{a: 8'h7F, b: 8'h7F, cin: 1'b1, s: 8'hFF, c: 1'b0, ov: 1'b1};
    vecs[7] = '{a: 8'hFF, b: 8'hFF, cin: 1'b1, s: 8'hFF, c: 1'b1, ov: 1'b0};

    rst = 1'b1;
    for (int d = 0; d < 3; d++) begin
      start_v[d] = 1'b0; a_v[d] = '0; b_v[d] = '0; cin_v[d] = 1'b0;
    end
    repeat (2) @(posedge clk);
    #1;
    for (int d = 0; d < 3; d++) begin
      check($sformatf("reset%0d.busy", d), 32'(busy_v[d]), 32'd0);
      check($sformatf("reset%0d.done", d), 32'(done_v[d]), 32'd0);
      check($sformatf("reset%0d.S", d), 32'(s_v[d]), 32'd0);
      check($sformatf("reset%0d.C", d), 32'(c_v[d]), 32'd0);
      check($sformatf("reset%0d.OV", d), 32'(ov_v[d]), 32'd0);
    end
    rst = 1'b0;

    // Directed table on CHUNK=2, then the same table on the other chunk sizes
    for (int d = 0; d < 3; d++) begin
      for (int i = 0; i < 8; i++) begin
        run_add(d, vecs[i].a, vecs[i].b, vecs[i].cin, vecs[i].s, vecs[i].c, vecs[i].ov,
                $sformatf("tbl_d%0d_v%0d", d, i));
      end
    end

    // Start held high through done: second add accepted in the done cycle
    @(negedge clk);
    start_v[0] = 1'b1; a_v[0] = 8'h00; b_v[0] = 8'h00; cin_v[0] = 1'b1;
    @(posedge clk); #1;
    a_v[0] = 8'h12; b_v[0] = 8'h34; cin_v[0] = 1'b0;
    lat = 0;
    while (!done_v[0] && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    check("b2b.first_latency", 32'(lat), 32'd4);
    check("b2b.first_S", 32'(s_v[0]), 32'h01);
    check("b2b.first_C", 32'(c_v[0]), 32'd0);
    @(posedge clk); #1;
    check("b2b.second_busy", 32'(busy_v[0]), 32'd1);
    check("b2b.second_done", 32'(done_v[0]), 32'd0);
    start_v[0] = 1'b0;
    lat = 0;
    while (!done_v[0] && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    check("b2b.second_latency", 32'(lat), 32'd4);
    check("b2b.second_S", 32'(s_v[0]), 32'h46);

    // Start and operand changes while busy are ignored
    @(negedge clk);
    start_v[0] = 1'b1; a_v[0] = 8'h12; b_v[0] = 8'h34; cin_v[0] = 1'b0;
    @(posedge clk); #1;
    a_v[0] = 8'hFF; b_v[0] = 8'hFF; cin_v[0] = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    start_v[0] = 1'b0;
    ndone = 0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      if (done_v[0]) ndone++;
    end
    check("busy_start.done_count", 32'(ndone), 32'd1);
    check("busy_start.S", 32'(s_v[0]), 32'h46);
    check("busy_start.C", 32'(c_v[0]), 32'd0);
    check("busy_start.OV", 32'(ov_v[0]), 32'd0);

    // Reset mid-operation aborts with no done
    @(negedge clk);
    start_v[0] = 1'b1; a_v[0] = 8'hAA; b_v[0] = 8'h55; cin_v[0] = 1'b0;
    @(posedge clk); #1;
    start_v[0] = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    check("abort.busy", 32'(busy_v[0]), 32'd0);
    check("abort.done", 32'(done_v[0]), 32'd0);
    check("abort.S", 32'(s_v[0]), 32'd0);
    check("abort.C", 32'(c_v[0]), 32'd0);
    check("abort.OV", 32'(ov_v[0]), 32'd0);
    rst = 1'b0;
    ndone = 0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      if (done_v[0]) ndone++;
    end
    check("abort.no_done", 32'(ndone), 32'd0);

    // Random vectors on CHUNK=8 and CHUNK=1 against an 8-bit sum model
    for (int d = 1; d < 3; d++) begin
      for (int i = 0; i < 1000; i++) begin
        ra = 8'($urandom);
        rb = 8'($urandom);
        rc = 1'($urandom);
        {ec, es} = 9'(ra) + 9'(rb) + 9'(rc);
        eov = (ra[7] == rb[7]) && (es[7] != ra[7]);
        run_add(d, ra, rb, rc, es, ec, eov, $sformatf("rnd_d%0d_%0d", d, i));
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
